// File: rtl/fix_session_if.sv
// Session manager bus: application/TOE requests in, FIFO requests and status out.
interface fix_session_if #(
  parameter int unsigned NUM_HOSTS = 4,
  parameter int unsigned HOST_W    = $clog2(NUM_HOSTS)
);
  logic                 connect_i;
  logic [HOST_W-1:0]    connect_to_host_i;
  logic                 disconnect_i;
  logic [HOST_W-1:0]    disconnect_host_i;
  logic                 connected_i;
  logic [HOST_W-1:0]    connected_host_addr_i;
  logic                 connect_req_o;
  logic [HOST_W-1:0]    connect_addr_o;
  logic                 disconnect_o;
  logic [HOST_W-1:0]    disconnect_host_num_o;
  logic [NUM_HOSTS-1:0] session_up_o;
  logic                 busy_o;
  logic                 conn_fail_o;
  logic [HOST_W-1:0]    fail_host_o;

  // Requester side: drives connect/disconnect/ack, observes status.
  modport master (
    output connect_i, connect_to_host_i, disconnect_i, disconnect_host_i,
           connected_i, connected_host_addr_i,
    input  connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
           session_up_o, busy_o, conn_fail_o, fail_host_o
  );

  // Session manager side.
  modport slave (
    input  connect_i, connect_to_host_i, disconnect_i, disconnect_host_i,
           connected_i, connected_host_addr_i,
    output connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
           session_up_o, busy_o, conn_fail_o, fail_host_o
  );
endinterface

// File: rtl/fix_session_mgr.sv
// FIX session manager: one outstanding connect with timeout/retry, per-host
// session tracking, and disconnect handling (including abort of a pending connect).
module fix_session_mgr #(
  parameter int unsigned NUM_HOSTS   = 4,
  parameter int unsigned HOST_W      = $clog2(NUM_HOSTS),
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned MAX_TRY     = 3
) (
  input logic         clk,
  input logic         rst,
  fix_session_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC);
  localparam int unsigned TRY_W  = $clog2(MAX_TRY + 1);
  localparam int unsigned HOST_N = 1 << HOST_W;
  // One bit per encodable address; set only for addresses below NUM_HOSTS.
  localparam logic [HOST_N-1:0] HOST_VALID = HOST_N'((64'd1 << NUM_HOSTS) - 64'd1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state;
  logic [HOST_W-1:0] cur_host;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [TRY_W-1:0]  tries;

  logic disc_valid_c;
  logic disc_clear_c;
  logic abort_c;
  logic conn_ok_c;
  logic ack_c;
  logic tmo_c;

  // Request qualification; a same-target disconnect suppresses the connect.
  assign disc_valid_c = bus.disconnect_i && HOST_VALID[bus.disconnect_host_i];
  assign disc_clear_c = disc_valid_c && bus.session_up_o[bus.disconnect_host_i];
  assign abort_c      = disc_valid_c && (state != IDLE) && (bus.disconnect_host_i == cur_host);
  assign conn_ok_c    = bus.connect_i && HOST_VALID[bus.connect_to_host_i]
                        && !bus.session_up_o[bus.connect_to_host_i]
                        && !(disc_valid_c && (bus.disconnect_host_i == bus.connect_to_host_i));
  assign ack_c        = (state == WAIT) && bus.connected_i && (bus.connected_host_addr_i == cur_host);
  assign tmo_c        = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Connect FSM, session bitmap and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                     <= IDLE;
      cur_host                  <= '0;
      tmo_cnt                   <= '0;
      tries                     <= '0;
      bus.connect_req_o         <= 1'b0;
      bus.connect_addr_o        <= '0;
      bus.disconnect_o          <= 1'b0;
      bus.disconnect_host_num_o <= '0;
      bus.session_up_o          <= '0;
      bus.busy_o                <= 1'b0;
      bus.conn_fail_o           <= 1'b0;
      bus.fail_host_o           <= '0;
    end else begin
      bus.connect_req_o <= 1'b0;
      bus.disconnect_o  <= 1'b0;
      bus.conn_fail_o   <= 1'b0;

      if (disc_clear_c) bus.session_up_o[bus.disconnect_host_i] <= 1'b0;
      if (disc_clear_c || abort_c) begin
        bus.disconnect_o          <= 1'b1;
        bus.disconnect_host_num_o <= bus.disconnect_host_i;
      end

      if (abort_c) begin
        state      <= IDLE;
        bus.busy_o <= 1'b0;
        tries      <= '0;
        tmo_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (conn_ok_c) begin
              cur_host           <= bus.connect_to_host_i;
              tries              <= TRY_W'(1);
              state              <= REQ;
              bus.connect_req_o  <= 1'b1;
              bus.connect_addr_o <= bus.connect_to_host_i;
              bus.busy_o         <= 1'b1;
            end
          end
          REQ: begin
            state   <= WAIT;
            tmo_cnt <= '0;
          end
          WAIT: begin
            if (ack_c) begin
              bus.session_up_o[cur_host] <= 1'b1;
              state                      <= IDLE;
              bus.busy_o                 <= 1'b0;
            end else if (tmo_c) begin
              if (tries < TRY_W'(MAX_TRY)) begin
                tries              <= tries + TRY_W'(1);
                state              <= REQ;
                bus.connect_req_o  <= 1'b1;
                bus.connect_addr_o <= cur_host;
                tmo_cnt            <= '0;
              end else begin
                bus.conn_fail_o <= 1'b1;
                bus.fail_host_o <= cur_host;
                state           <= IDLE;
                bus.busy_o      <= 1'b0;
              end
            end else begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
          end
          default: begin
            state      <= IDLE;
            bus.busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fix_session_mgr.sv
// Directed bench for fix_session_mgr (4 hosts, 8-cycle timeout, 3 tries).
module tb_fix_session_mgr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  fix_session_if #(.NUM_HOSTS(4), .HOST_W(2)) bus ();

  fix_session_mgr #(
    .NUM_HOSTS(4), .HOST_W(2), .TIMEOUT_CYC(8), .MAX_TRY(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.connect_i             = 1'b0;
    bus.connect_to_host_i     = '0;
    bus.disconnect_i          = 1'b0;
    bus.disconnect_host_i     = '0;
    bus.connected_i           = 1'b0;
    bus.connected_host_addr_i = '0;
  endtask

  task automatic count_pulses(input int n, output int nreq, output int nfail, output int ndisc);
    nreq = 0; nfail = 0; ndisc = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      nreq  += int'(bus.connect_req_o);
      nfail += int'(bus.conn_fail_o);
      ndisc += int'(bus.disconnect_o);
    end
  endtask

  // Connect h and acknowledge it in the first WAIT cycle.
  task automatic bring_up(input logic [1:0] h);
    bus.connect_i = 1'b1; bus.connect_to_host_i = h;
    tick();
    bus.connect_i = 1'b0;
    tick();
    bus.connected_i = 1'b1; bus.connected_host_addr_i = h;
    tick();
    bus.connected_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_session"},  32'(bus.session_up_o), 32'h0);
    chk({pfx, "_req"},      32'(bus.connect_req_o), 32'h0);
    chk({pfx, "_disc"},     32'(bus.disconnect_o), 32'h0);
    chk({pfx, "_fail"},     32'(bus.conn_fail_o), 32'h0);
    chk({pfx, "_busy"},     32'(bus.busy_o), 32'h0);
    chk({pfx, "_addr"},     32'(bus.connect_addr_o), 32'h0);
    chk({pfx, "_disc_num"}, 32'(bus.disconnect_host_num_o), 32'h0);
    chk({pfx, "_fail_host"},32'(bus.fail_host_o), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1);
  end

  initial begin
    int req_at[$];
    int fail_n, fail_at, nreq, nfail, ndisc;
    logic [1:0] fhost;

    idle_in();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");

    // Connect host 2 on the first edge after release; ack in IDLE is ignored.
    rst = 1'b0;
    bus.connect_i = 1'b1; bus.connect_to_host_i = 2'd2;
    bus.connected_i = 1'b1; bus.connected_host_addr_i = 2'd2;
    tick();
    chk("c2_req", 32'(bus.connect_req_o), 32'h1);
    chk("c2_addr", 32'(bus.connect_addr_o), 32'h2);
    chk("c2_busy", 32'(bus.busy_o), 32'h1);
    chk("c2_idle_ack_ignored", 32'(bus.session_up_o), 32'h0);
    bus.connect_i = 1'b0;                // ack during REQ is ignored too
    tick();
    chk("c2_req_one_cycle", 32'(bus.connect_req_o), 32'h0);
    chk("c2_req_ack_ignored", 32'(bus.session_up_o), 32'h0);
    chk("c2_busy_wait", 32'(bus.busy_o), 32'h1);
    bus.connected_i = 1'b0;
    tick();
    bus.connected_i = 1'b1;              // three edges after the connect edge
    tick();
    bus.connected_i = 1'b0;
    chk("c2_session", 32'(bus.session_up_o), 32'h4);
    chk("c2_busy_done", 32'(bus.busy_o), 32'h0);

    // Same-target connect + disconnect: only the disconnect happens.
    bus.disconnect_i = 1'b1; bus.disconnect_host_i = 2'd2;
    bus.connect_i = 1'b1; bus.connect_to_host_i = 2'd2;
    tick();
    chk("dc2_disc", 32'(bus.disconnect_o), 32'h1);
    chk("dc2_num", 32'(bus.disconnect_host_num_o), 32'h2);
    chk("dc2_session", 32'(bus.session_up_o), 32'h0);
    chk("dc2_no_req", 32'(bus.connect_req_o), 32'h0);
    chk("dc2_no_busy", 32'(bus.busy_o), 32'h0);
    idle_in();
    tick();
    chk("dc2_disc_pulse", 32'(bus.disconnect_o), 32'h0);

    // Host 1 never acked: three requests 9 cycles apart, then one failure.
    bus.connect_i = 1'b1; bus.connect_to_host_i = 2'd1;
    fail_n = 0; fail_at = 0; fhost = 2'd0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 1) bus.connect_i = 1'b0;
      if (t == 5) chk("retry_busy", 32'(bus.busy_o), 32'h1);
      if (bus.connect_req_o) begin
        req_at.push_back(t);
        chk("retry_addr", 32'(bus.connect_addr_o), 32'h1);
      end
      if (bus.conn_fail_o) begin
        fail_n++; fail_at = t; fhost = bus.fail_host_o;
      end
    end
    chk("retry_count", 32'(req_at.size()), 32'd3);
    if (req_at.size() == 3) begin
      chk("retry_first", 32'(req_at[0]), 32'd1);
      chk("retry_gap1", 32'(req_at[1] - req_at[0]), 32'd9);
      chk("retry_gap2", 32'(req_at[2] - req_at[1]), 32'd9);
    end
    chk("fail_count", 32'(fail_n), 32'd1);
    chk("fail_cycle", 32'(fail_at), 32'd28);
    chk("fail_host", 32'(fhost), 32'h1);
    chk("fail_session", 32'(bus.session_up_o), 32'h0);
    chk("fail_busy", 32'(bus.busy_o), 32'h0);

    // Connect to an already-up host is ignored; disconnect tears it down.
    bring_up(2'd0);
    chk("h0_session", 32'(bus.session_up_o), 32'h1);
    bus.connect_i = 1'b1; bus.connect_to_host_i = 2'd0;
    tick();
    chk("h0_up_no_req", 32'(bus.connect_req_o), 32'h0);
    chk("h0_up_no_busy", 32'(bus.busy_o), 32'h0);
    bus.connect_i = 1'b0;
    bus.disconnect_i = 1'b1; bus.disconnect_host_i = 2'd0;
    tick();
    bus.disconnect_i = 1'b0;
    chk("h0_disc", 32'(bus.disconnect_o), 32'h1);
    chk("h0_disc_num", 32'(bus.disconnect_host_num_o), 32'h0);
    chk("h0_session_clr", 32'(bus.session_up_o), 32'h0);

    // Busy drop of host 3, stray ack for 3, matching ack on the timeout edge.
    bus.connect_i = 1'b1; bus.connect_to_host_i = 2'd1;
    tick();                                  // t1: REQ
    bus.connect_i = 1'b0;
    tick();                                  // t2: WAIT cnt 0
    bus.connect_i = 1'b1; bus.connect_to_host_i = 2'd3;
    tick();                                  // t3
    chk("busy_drop_req", 32'(bus.connect_req_o), 32'h0);
    bus.connect_i = 1'b0;
    bus.connected_i = 1'b1; bus.connected_host_addr_i = 2'd3;
    tick();                                  // t4
    bus.connected_i = 1'b0;
    chk("stray_ack_session", 32'(bus.session_up_o), 32'h0);
    chk("stray_ack_busy", 32'(bus.busy_o), 32'h1);
    count_pulses(5, nreq, nfail, ndisc);     // t5..t9, counter reaches 7
    chk("pre_tmo_req", 32'(nreq), 32'd0);
    bus.connected_i = 1'b1; bus.connected_host_addr_i = 2'd1;
    tick();                                  // t10: ack wins over timeout
    bus.connected_i = 1'b0;
    chk("tmo_ack_session", 32'(bus.session_up_o), 32'h2);
    chk("tmo_ack_busy", 32'(bus.busy_o), 32'h0);
    chk("tmo_ack_no_req", 32'(bus.connect_req_o), 32'h0);
    count_pulses(20, nreq, nfail, ndisc);
    chk("tmo_ack_later_req", 32'(nreq), 32'd0);
    chk("tmo_ack_later_fail", 32'(nfail), 32'd0);

    // Abort a pending connect for host 1 by disconnecting it.
    bus.disconnect_i = 1'b1; bus.disconnect_host_i = 2'd1;
    tick();
    bus.disconnect_i = 1'b0;
    chk("h1_down", 32'(bus.session_up_o), 32'h0);
    bus.connect_i = 1'b1; bus.connect_to_host_i = 2'd1;
    tick();
    bus.connect_i = 1'b0;
    tick();
    bus.disconnect_i = 1'b1; bus.disconnect_host_i = 2'd1;
    tick();
    bus.disconnect_i = 1'b0;
    chk("abort_disc", 32'(bus.disconnect_o), 32'h1);
    chk("abort_num", 32'(bus.disconnect_host_num_o), 32'h1);
    chk("abort_busy", 32'(bus.busy_o), 32'h0);
    chk("abort_fail", 32'(bus.conn_fail_o), 32'h0);
    count_pulses(20, nreq, nfail, ndisc);
    chk("abort_later_fail", 32'(nfail), 32'd0);
    chk("abort_later_req", 32'(nreq), 32'd0);
    bus.connected_i = 1'b1; bus.connected_host_addr_i = 2'd1;
    tick();
    bus.connected_i = 1'b0;
    chk("abort_late_ack", 32'(bus.session_up_o), 32'h0);

    // Connect 0 and disconnect 3 in the same IDLE cycle.
    bring_up(2'd3);
    chk("h3_session", 32'(bus.session_up_o), 32'h8);
    bus.connect_i = 1'b1; bus.connect_to_host_i = 2'd0;
    bus.disconnect_i = 1'b1; bus.disconnect_host_i = 2'd3;
    tick();
    idle_in();
    chk("both_req", 32'(bus.connect_req_o), 32'h1);
    chk("both_addr", 32'(bus.connect_addr_o), 32'h0);
    chk("both_disc", 32'(bus.disconnect_o), 32'h1);
    chk("both_num", 32'(bus.disconnect_host_num_o), 32'h3);
    chk("both_session", 32'(bus.session_up_o), 32'h0);
    tick();
    bus.connected_i = 1'b1; bus.connected_host_addr_i = 2'd0;
    tick();
    bus.connected_i = 1'b0;
    chk("both_ack0", 32'(bus.session_up_o), 32'h1);
    bring_up(2'd3);
    chk("pre_rst_session", 32'(bus.session_up_o), 32'h9);

    // Mid-cycle reset while waiting on host 1.
    bus.connect_i = 1'b1; bus.connect_to_host_i = 2'd1;
    tick();
    bus.connect_i = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    count_pulses(30, nreq, nfail, ndisc);
    chk("post_rst_req", 32'(nreq), 32'd0);
    chk("post_rst_fail", 32'(nfail), 32'd0);
    chk("post_rst_disc", 32'(ndisc), 32'd0);
    chk("post_rst_session", 32'(bus.session_up_o), 32'h0);
    chk("post_rst_busy", 32'(bus.busy_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fix_session_mgr.md
FIX_SESSION_MGR -- requirements
Module: fix_session_mgr

Interface
REQ-001 Parameter: NUM_HOSTS, 4, number of remote hosts tracked; legal range 2..16.
REQ-002 Parameter: HOST_W, $clog2(NUM_HOSTS), host address width.
REQ-003 Parameter: TIMEOUT_CYC, 64, cycles to wait for a connect acknowledge; legal range 2..65535.
REQ-004 Parameter: MAX_TRY, 3, total connect attempts per request, including the first; legal range 1..15.
REQ-005 Port: clk  in  1  sole clock; all logic is rising-edge.
REQ-006 Port: rst  in  1  asynchronous, active-high reset.
REQ-007 Port: connect_i  in  1  application connect request, one-cycle pulse.
REQ-008 Port: connect_to_host_i  in  HOST_W  target host for connect_i.
REQ-009 Port: disconnect_i  in  1  application disconnect request, one-cycle pulse.
REQ-010 Port: disconnect_host_i  in  HOST_W  target host for disconnect_i.
REQ-011 Port: connected_i  in  1  acknowledge from the TOE, one-cycle pulse.
REQ-012 Port: connected_host_addr_i  in  HOST_W  host being acknowledged.
REQ-013 Port: connect_req_o  out  1  connect request to the FIFO, one-cycle pulse.
REQ-014 Port: connect_addr_o  out  HOST_W  host for connect_req_o; held until the next request.
REQ-015 Port: disconnect_o  out  1  disconnect request to the FIFO, one-cycle pulse.
REQ-016 Port: disconnect_host_num_o  out  HOST_W  host for disconnect_o; held until the next disconnect.
REQ-017 Port: session_up_o  out  NUM_HOSTS  bit h is high while host h is connected.
REQ-018 Port: busy_o  out  1  high while a connect is outstanding (any state other than IDLE).
REQ-019 Port: conn_fail_o  out  1  one-cycle pulse when all attempts for a connect are exhausted.
REQ-020 Port: fail_host_o  out  HOST_W  host for conn_fail_o; held until the next failure.

Function
REQ-021 The connect FSM shall have the states IDLE, REQ, WAIT; only one connect shall be outstanding at a time.
REQ-022 In IDLE, a connect_i targeting host h whose session bit is 0 shall latch h, clear the try count to 1 and enter REQ.
REQ-023 In IDLE, a connect_i targeting a host whose session bit is 1 shall be ignored; no pulse is issued.
REQ-024 A connect_i arriving while busy_o=1 shall be dropped, not queued.
REQ-025 REQ shall last exactly one cycle: connect_req_o=1, connect_addr_o=h, then enter WAIT with the timeout counter at 0.
REQ-026 Latency: connect_i sampled at edge N shall give connect_req_o high in cycle N+1.
REQ-027 In WAIT, connected_i with connected_host_addr_i=h shall set session_up_o[h] on the next edge and return to IDLE.
REQ-028 connected_i with a non-matching address, or arriving in IDLE or REQ, shall be ignored and shall not change session_up_o.
REQ-029 In WAIT, the counter shall increment once per cycle; on reaching TIMEOUT_CYC-1 without a matching ack, the FSM shall act as follows:
- if tries < MAX_TRY: increment tries and re-enter REQ;
- otherwise: pulse conn_fail_o with fail_host_o=h and enter IDLE.
REQ-030 A matching ack in the same cycle as the timeout shall win: the session comes up and no retry or failure occurs.
REQ-031 disconnect_i targeting host d whose session bit is 1 shall, on the next edge, clear bit d and pulse disconnect_o with disconnect_host_num_o=d.
REQ-032 disconnect_i targeting host d whose session bit is 0 shall be ignored, except in the abort case of REQ-033.
REQ-033 disconnect_i targeting the host currently in REQ or WAIT shall abort the connect: the FSM enters IDLE, disconnect_o pulses, and conn_fail_o does not pulse.
REQ-034 disconnect_i and connect_i in the same IDLE cycle shall both be processed, independently and in the same cycle, when their targets differ.
REQ-035 disconnect_i and connect_i in the same IDLE cycle with the same target shall process the disconnect only.
REQ-036 Addresses of NUM_HOSTS or above (for non-power-of-two NUM_HOSTS) shall be ignored on every input.

Reset
REQ-037 While rst=1, regardless of clk:
- FSM forced to IDLE; counters and the try count cleared;
- session_up_o=0; connect_req_o, disconnect_o, conn_fail_o and busy_o all 0;
- connect_addr_o, disconnect_host_num_o and fail_host_o all 0.
REQ-038 Reset asserted mid-connect shall abandon the attempt, with no conn_fail_o pulse after release.
REQ-039 The first connect_i is accepted on the first edge after rst deasserts.

Verification
REQ-040 Reset, then connect_i with host 2, then connected_i with addr 2 three cycles later -> connect_req_o pulses in the cycle after connect_i with connect_addr_o=2; session_up_o=4'b0100; busy_o=0.
REQ-041 TIMEOUT_CYC=8, MAX_TRY=3, connect_i with host 1 and no ack -> exactly 3 connect_req_o pulses, 9 cycles apart; then conn_fail_o pulses once with fail_host_o=1; session_up_o=0.
REQ-042 Host 0 up, then connect_i with host 0, then disconnect_i with host 0 -> no connect_req_o; then disconnect_o pulses with disconnect_host_num_o=0; session_up_o[0]=0.
REQ-043 A second connect_i (host 3) during WAIT for host 1; an ack for addr 3 during that wait; an ack for addr 1 in the timeout cycle -> host 3 ignored; session_up_o=4'b0010; no retry and no conn_fail_o.
REQ-044 disconnect_i with host 1 during WAIT for host 1 -> FSM returns to IDLE; disconnect_o pulses; no conn_fail_o; a later connected_i with addr 1 is ignored.
REQ-045 rst pulsed asynchronously (mid-cycle) during WAIT with session_up_o=4'b1001 -> all outputs are 0 immediately and no pulse occurs after release.
